// File: rtl/stream_demux.sv
// 1-to-2 registered stream demultiplexer: each word on the valid/ready input is
// steered by In_Select into a one-word register on channel 0 or 1, with per-channel delivery counters.
module stream_demux #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [WIDTH-1:0]     In_Data,
  input  logic                 In_Select,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [WIDTH-1:0]     Out0_Data,
  output logic                 Out0_Valid,
  input  logic                 Out0_Ready,
  output logic [WIDTH-1:0]     Out1_Data,
  output logic                 Out1_Valid,
  input  logic                 Out1_Ready,
  input  logic                 Clear,
  output logic [CNT_WIDTH-1:0] Count0,
  output logic [CNT_WIDTH-1:0] Count1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  chan_state_e          state_q [2];
  chan_state_e          state_d [2];
  logic [WIDTH-1:0]     data_q  [2];
  logic [WIDTH-1:0]     data_d  [2];
  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic [CNT_WIDTH-1:0] cnt_d   [2];
  logic [1:0]           out_ready;
  logic [1:0]           drain;
  logic [1:0]           load;
  logic                 accept;

  assign out_ready = {Out1_Ready, Out0_Ready};

  // Ready looks only at the selected channel so a stalled sibling never blocks traffic.
  always_comb begin
    In_Ready = 1'b0;
    if (In_Select) begin
      In_Ready = (state_q[1] == EMPTY) | Out1_Ready;
    end else begin
      In_Ready = (state_q[0] == EMPTY) | Out0_Ready;
    end
  end

  assign accept  = In_Valid & In_Ready;
  assign load[0] = accept & ~In_Select;
  assign load[1] = accept & In_Select;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      cnt_d[i]   = cnt_q[i];
      drain[i]   = (state_q[i] == FULL) & out_ready[i];
      // A same-cycle load wins over a drain so the register reloads and stays FULL.
      if (load[i]) begin
        state_d[i] = FULL;
        data_d[i]  = In_Data;
      end else if (drain[i]) begin
        state_d[i] = EMPTY;
      end
      if (Clear) begin
        cnt_d[i] = '0;
      end else if (drain[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign Out0_Valid = (state_q[0] == FULL);
  assign Out1_Valid = (state_q[1] == FULL);
  assign Out0_Data  = data_q[0];
  assign Out1_Data  = data_q[1];
  assign Count0     = cnt_q[0];
  assign Count1     = cnt_q[1];

endmodule
